video_frame_checker: RTL and testbench

Synthesizable sink-side checker for the parallel RGB video stream recovered by the LVDS 7:1 receiver. It sits on the receiver's pixel-clock outputs (vs/hs/de/RGB), measures frame geometry, computes a per-frame pixel checksum, and declares lock after consecutive conforming frames. It is the hardware counterpart of the BMP video driver: it gives on-chip and bench-visible pass/fail for the same stream the driver produces.

---
 rtl/video_chk_pkg.sv | 20 ++
 rtl/video_edge_det.sv | 36 +++
 rtl/video_frame_checker.sv | 234 +++++++++++++++++++++++
 tb/tb_video_frame_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/video_chk_pkg.sv
// Shared types and constants for the video frame checker.
package video_chk_pkg;

  // Checker lock state.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam int CHK_W = 32;  // checksum width
  localparam int ERR_W = 16;  // error / frame counter width

  // Edge detector lane indices.
  localparam int LANE_VS = 0;
  localparam int LANE_HS = 1;
  localparam int LANE_DE = 2;
  localparam int LANE_N  = 3;

endpackage

// File: rtl/video_edge_det.sv
// Registers one control signal and produces level, leading-edge and
// falling-edge strobes that are all aligned to the same pipeline stage.
module video_edge_det (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic level,
  output logic lead,
  output logic fall
);

  logic sync_reg;
  logic prev_reg;
  logic lead_reg;
  logic fall_reg;

  // Two-stage history; strobes are registered so they line up with prev_reg.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
      lead_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= din;
      prev_reg <= sync_reg;
      lead_reg <= sync_reg & ~prev_reg;
      fall_reg <= ~sync_reg & prev_reg;
    end
  end

  assign level = prev_reg;
  assign lead  = lead_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/video_frame_checker.sv
// Sink-side checker for a parallel RGB stream: measures frame geometry,
// sums pixels per frame and declares lock after consecutive good frames.
module video_frame_checker
  import video_chk_pkg::*;
#(
  parameter int   H_ACTIVE    = 160,
  parameter int   V_ACTIVE    = 120,
  parameter int   LOCK_FRAMES = 2,
  parameter int   CNT_W       = 12,
  parameter logic SYNC_POL    = 1'b1
) (
  input  logic             I_pix_clk,
  input  logic             I_rst,
  input  logic             I_vs,
  input  logic             I_hs,
  input  logic             I_de,
  input  logic [7:0]       I_data_r,
  input  logic [7:0]       I_data_g,
  input  logic [7:0]       I_data_b,
  output logic             O_frame_done,
  output logic [CNT_W-1:0] O_h_active,
  output logic [CNT_W-1:0] O_v_active,
  output logic [CNT_W-1:0] O_h_total,
  output logic [CNT_W-1:0] O_v_total,
  output logic [31:0]      O_checksum,
  output logic             O_locked,
  output logic             O_size_err,
  output logic [15:0]      O_err_cnt,
  output logic [15:0]      O_frame_cnt
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Syncs are normalised to active-high before edge detection.
  logic [LANE_N-1:0] raw_in;
  logic [LANE_N-1:0] lvl;
  logic [LANE_N-1:0] lead;
  logic [LANE_N-1:0] fall;

  assign raw_in[LANE_VS] = I_vs ^ ~SYNC_POL;
  assign raw_in[LANE_HS] = I_hs ^ ~SYNC_POL;
  assign raw_in[LANE_DE] = I_de;

  for (genvar gi = 0; gi < LANE_N; gi++) begin : g_edge
    video_edge_det u_edge (
      .clk  (I_pix_clk),
      .srst (I_rst),
      .din  (raw_in[gi]),
      .level(lvl[gi]),
      .lead (lead[gi]),
      .fall (fall[gi])
    );
  end

  logic vs_lead, hs_lead, de_lvl, de_fall;
  assign vs_lead = lead[LANE_VS];
  assign hs_lead = lead[LANE_HS];
  assign de_lvl  = lvl[LANE_DE];
  assign de_fall = fall[LANE_DE];

  logic unused_edges;
  assign unused_edges = ^{lvl[LANE_HS:LANE_VS], fall[LANE_HS:LANE_VS], lead[LANE_DE]};

  // Pixel data delayed to line up with the de level from the edge detector.
  logic [23:0] pix_s1_reg, pix_s2_reg;

  // Two-stage pixel pipeline.
  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      pix_s1_reg <= '0;
      pix_s2_reg <= '0;
    end else begin
      pix_s1_reg <= {I_data_b, I_data_g, I_data_r};
      pix_s2_reg <= pix_s1_reg;
    end
  end

  // Run-time measurement state.
  chk_state_t       state_reg, state_next;
  logic [3:0]       match_cnt_reg, match_next;
  logic [CNT_W-1:0] h_tot_cnt_reg, h_total_run_reg, v_tot_cnt_reg;
  logic [CNT_W-1:0] h_cnt_reg, v_cnt_reg, h_act_run_reg;
  logic             first_seen_reg, line_bad_reg;
  logic [CHK_W-1:0] csum_run_reg;
  logic             publish, conform, active;

  // Published outputs.
  logic             frame_done_reg, size_err_reg;
  logic [CNT_W-1:0] h_active_reg, v_active_reg, h_total_reg, v_total_reg;
  logic [CHK_W-1:0] checksum_reg;
  logic [ERR_W-1:0] err_cnt_reg, frame_cnt_reg;

  assign conform = (h_act_run_reg == H_ACT_C) && (v_cnt_reg == V_ACT_C) && !line_bad_reg;
  // The vs_lead that arms the checker also opens the first measured frame.
  assign active  = (state_reg != SEARCH) || vs_lead;

  // Lock FSM next state: publish on every vs_lead once armed.
  always_comb begin
    state_next = state_reg;
    match_next = match_cnt_reg;
    publish    = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (vs_lead) state_next = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (vs_lead) begin
          publish = 1'b1;
          if (conform) begin
            if (match_cnt_reg < LOCK_C) match_next = match_cnt_reg + 4'd1;
            if (match_next >= LOCK_C) state_next = LOCKED;
          end else begin
            match_next = 4'd0;
            state_next = MEASURE;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      state_reg     <= SEARCH;
      match_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_next;
    end
  end

  // Geometry counters, checksum and publication of frame results.
  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      h_tot_cnt_reg   <= '0;
      h_total_run_reg <= '0;
      v_tot_cnt_reg   <= '0;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      h_act_run_reg   <= '0;
      first_seen_reg  <= 1'b0;
      line_bad_reg    <= 1'b0;
      csum_run_reg    <= '0;
      frame_done_reg  <= 1'b0;
      size_err_reg    <= 1'b0;
      h_active_reg    <= '0;
      v_active_reg    <= '0;
      h_total_reg     <= '0;
      v_total_reg     <= '0;
      checksum_reg    <= '0;
      err_cnt_reg     <= '0;
      frame_cnt_reg   <= '0;
    end else begin
      frame_done_reg <= publish;
      size_err_reg   <= publish & ~conform;
      if (publish) begin
        h_active_reg  <= h_act_run_reg;
        v_active_reg  <= v_cnt_reg;
        h_total_reg   <= h_total_run_reg;
        v_total_reg   <= v_tot_cnt_reg;
        checksum_reg  <= csum_run_reg;
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
        if (!conform && !(&err_cnt_reg)) err_cnt_reg <= err_cnt_reg + 1'b1;
      end

      if (!active) begin
        h_tot_cnt_reg   <= '0;
        h_total_run_reg <= '0;
        v_tot_cnt_reg   <= '0;
        h_cnt_reg       <= '0;
        v_cnt_reg       <= '0;
        h_act_run_reg   <= '0;
        first_seen_reg  <= 1'b0;
        line_bad_reg    <= 1'b0;
        csum_run_reg    <= '0;
      end else begin
        // Line period timer runs across frame boundaries.
        if (hs_lead) begin
          h_tot_cnt_reg   <= CNT_W'(1);
          h_total_run_reg <= h_tot_cnt_reg;
        end else begin
          h_tot_cnt_reg <= sat_inc(h_tot_cnt_reg);
        end

        if (vs_lead) begin
          // Events coincident with vs_lead belong to the new frame; a de
          // fall in this cycle is dropped since its line straddles frames.
          v_tot_cnt_reg  <= hs_lead ? CNT_W'(1) : '0;
          h_cnt_reg      <= de_lvl ? CNT_W'(1) : '0;
          v_cnt_reg      <= '0;
          h_act_run_reg  <= '0;
          first_seen_reg <= 1'b0;
          line_bad_reg   <= 1'b0;
          csum_run_reg   <= de_lvl ? {{(CHK_W-24){1'b0}}, pix_s2_reg} : '0;
        end else begin
          if (hs_lead) v_tot_cnt_reg <= sat_inc(v_tot_cnt_reg);
          if (de_lvl) begin
            h_cnt_reg    <= sat_inc(h_cnt_reg);
            csum_run_reg <= csum_run_reg + {{(CHK_W-24){1'b0}}, pix_s2_reg};
          end
          if (de_fall) begin
            v_cnt_reg <= sat_inc(v_cnt_reg);
            h_cnt_reg <= '0;
            if (!first_seen_reg) begin
              h_act_run_reg  <= h_cnt_reg;
              first_seen_reg <= 1'b1;
            end else if (h_cnt_reg != h_act_run_reg) begin
              line_bad_reg <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign O_frame_done = frame_done_reg;
  assign O_size_err   = size_err_reg;
  assign O_h_active   = h_active_reg;
  assign O_v_active   = v_active_reg;
  assign O_h_total    = h_total_reg;
  assign O_v_total    = v_total_reg;
  assign O_checksum   = checksum_reg;
  assign O_err_cnt    = err_cnt_reg;
  assign O_frame_cnt  = frame_cnt_reg;
  assign O_locked     = (state_reg == LOCKED);

endmodule

// File: tb/tb_video_frame_checker.sv
// Scoreboard bench: two checkers (active-high and active-low syncs) watch the
// same scaled-down frame stream; each publish is compared to queued results.
module tb_video_frame_checker;

  localparam int H_ACT = 20;
  localparam int V_ACT = 10;
  localparam int H_TOT = 28;
  localparam int V_TOT = 14;
  localparam logic [31:0] CS_ONES = 32'd200;       // 200 pixels of r=1
  localparam logic [31:0] CS_BAD  = 32'd199;       // one line 19 pixels
  localparam logic [31:0] CS_RAMP = 32'd39553900;  // r=x, g=y, b=3

  typedef struct {
    int          h_act, v_act, h_tot, v_tot;
    logic [31:0] csum;
    bit          err, lock;
    int          err_cnt, frame_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs_drv = 1'b0, hs_drv = 1'b0, de_drv = 1'b0;
  logic [7:0] r_drv = '0, g_drv = '0, b_drv = '0;

  logic [1:0]       fd, se, locked;
  logic [1:0][11:0] h_active, v_active, h_total, v_total;
  logic [1:0][31:0] checksum;
  logic [1:0][15:0] err_cnt, frame_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   rd_idx[2] = '{0, 0};
  int   exp_frames = 0;
  int   exp_errs = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    video_frame_checker #(
      .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(2), .CNT_W(12),
      .SYNC_POL(gi == 0 ? 1'b1 : 1'b0)
    ) dut (
      .I_pix_clk   (clk),
      .I_rst       (rst),
      .I_vs        (vs_drv ^ (gi == 1)),
      .I_hs        (hs_drv ^ (gi == 1)),
      .I_de        (de_drv),
      .I_data_r    (r_drv),
      .I_data_g    (g_drv),
      .I_data_b    (b_drv),
      .O_frame_done(fd[gi]),
      .O_h_active  (h_active[gi]),
      .O_v_active  (v_active[gi]),
      .O_h_total   (h_total[gi]),
      .O_v_total   (v_total[gi]),
      .O_checksum  (checksum[gi]),
      .O_locked    (locked[gi]),
      .O_size_err  (se[gi]),
      .O_err_cnt   (err_cnt[gi]),
      .O_frame_cnt (frame_cnt[gi])
    );
  end

  task automatic check(input string name, input int k, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, k, act, req);
    end
  endtask

  // Monitor: pop one expected record per published frame and compare.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && fd[k] === 1'b1) begin
        if (rd_idx[k] >= exp_q.size()) begin
          checks++;
          failures++;
          $display("FAIL unexpected_publish dut%0d: got frame_done, expected none", k);
        end else begin
          exp_t e;
          e = exp_q[rd_idx[k]];
          rd_idx[k]++;
          $display("publish dut%0d #%0d: h_act=%0d v_act=%0d h_tot=%0d v_tot=%0d csum=%0d err=%0b lock=%0b",
                   k, frame_cnt[k], h_active[k], v_active[k], h_total[k], v_total[k],
                   checksum[k], se[k], locked[k]);
          check("h_active", k, h_active[k], e.h_act);
          check("v_active", k, v_active[k], e.v_act);
          check("h_total", k, h_total[k], e.h_tot);
          check("v_total", k, v_total[k], e.v_tot);
          check("checksum", k, checksum[k], e.csum);
          check("size_err", k, se[k], e.err);
          check("locked", k, locked[k], e.lock);
          check("err_cnt", k, err_cnt[k], e.err_cnt);
          check("frame_cnt", k, frame_cnt[k], e.frame_cnt);
        end
      end else if (!rst && se[k] === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL stray_size_err dut%0d: got 1, expected 0 outside publish", k);
      end
    end
  end

  // One frame: vs on lines 0-1, hs on cycles 0-1, de on lines 2-11 cycles 4..
  task automatic drive_frame(input int stop_line, input int mode, input int bad_len,
                             input bit no_de, input logic [31:0] exp_csum,
                             input bit exp_err, input bit exp_lock, input bit push);
    int len;
    for (int y = 0; y < stop_line; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        @(negedge clk);
        vs_drv = (y < 2);
        hs_drv = (x < 2);
        len    = (y == 5 && bad_len != 0) ? bad_len : H_ACT;
        de_drv = !no_de && y >= 2 && y < 2 + V_ACT && x >= 4 && x < 4 + len;
        if (de_drv && mode == 0) begin
          r_drv = 8'd1; g_drv = 8'd0; b_drv = 8'd0;
        end else if (de_drv) begin
          r_drv = 8'(x - 4); g_drv = 8'(y - 2); b_drv = 8'd3;
        end else begin
          r_drv = 8'd0; g_drv = 8'd0; b_drv = 8'd0;
        end
      end
    end
    if (push) begin
      exp_frames++;
      if (exp_err) exp_errs++;
      exp_q.push_back('{no_de ? 0 : H_ACT, no_de ? 0 : V_ACT, H_TOT, V_TOT,
                        exp_csum, exp_err, exp_lock, exp_errs, exp_frames});
    end
  endtask

  task automatic apply_reset_and_check(input string tag);
    @(negedge clk);
    rst = 1'b1; vs_drv = 1'b0; hs_drv = 1'b0; de_drv = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_locked"}, k, locked[k], 0);
      check({tag, "_checksum"}, k, checksum[k], 0);
      check({tag, "_counts"}, k, {err_cnt[k], frame_cnt[k]}, 0);
      check({tag, "_geom"}, k, {fd[k], se[k], h_active[k], v_active[k], h_total[k], v_total[k]}, 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset_and_check("reset");
    // first vs arms; frames 1-2 lock; frame 3 bad line; relock; no-de frame
    drive_frame(V_TOT, 0, 0, 1'b0, CS_ONES, 1'b0, 1'b0, 1'b1);
    drive_frame(V_TOT, 1, 0, 1'b0, CS_RAMP, 1'b0, 1'b1, 1'b1);
    drive_frame(V_TOT, 0, 19, 1'b0, CS_BAD, 1'b1, 1'b0, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b0, CS_ONES, 1'b0, 1'b0, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b0, CS_ONES, 1'b0, 1'b1, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    drive_frame(V_TOT, 1, 0, 1'b0, CS_RAMP, 1'b0, 1'b0, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b0, CS_ONES, 1'b0, 1'b1, 1'b1);
    // partial frame while locked, then reset mid-frame: nothing published for it
    drive_frame(5, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply_reset_and_check("midreset");
    drive_frame(V_TOT, 1, 0, 1'b0, CS_RAMP, 1'b0, 1'b0, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b0, CS_ONES, 1'b0, 1'b1, 1'b1);
    drive_frame(V_TOT, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) check("publish_count", k, rd_idx[k], exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
